// File: rtl/tof_pkg.sv
// Shared constants and the FIFO word type for the ToF distance collector.
// TOF_TIMESTAMP_EN adds a timestamp field to the sample word.
package tof_pkg;

    localparam int TOF_N_SENSORS = 8;
    localparam int TOF_DIST_W    = 16;
    localparam int TOF_TS_W      = 16;
    localparam int TOF_IDX_W     = $clog2(TOF_N_SENSORS);

    typedef struct packed {
        logic [TOF_IDX_W-1:0]  index;
        logic [TOF_DIST_W-1:0] distance;
`ifdef TOF_TIMESTAMP_EN
        logic [TOF_TS_W-1:0]   timestamp;
`endif
    } tof_sample_t;

endpackage

// File: rtl/tof_sample_fifo.sv
// First-word-fall-through synchronous FIFO carrying tof_sample_t words.
// Head data reads as zero while empty so the outputs are clean after reset.
module tof_sample_fifo
    import tof_pkg::*;
#(
    parameter int  DEPTH = 16,
    parameter type T     = tof_sample_t
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  T                       push_data,
    input  logic                   pop,
    output T                       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          do_push, do_pop;
    T              mem_q [DEPTH];

    always_comb begin
        full     = (level_q == (AW+1)'(DEPTH));
        empty    = (level_q == '0);
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        level_d  = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        pop_data = empty ? '0 : mem_q[rd_ptr_q];
        level    = level_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: unread entries are masked by the level.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/tof_distance_collector.sv
// Collects per-sensor ToF distance strobes into pending slots, round-robin
// arbitrates them into a FWFT FIFO. TOF_TIMESTAMP_EN adds sample timestamps.
module tof_distance_collector
    import tof_pkg::*;
#(
    parameter int N_SENSORS = TOF_N_SENSORS,
    parameter int DIST_W    = TOF_DIST_W,
    parameter int DEPTH     = 16
`ifdef TOF_TIMESTAMP_EN
    ,
    parameter int TS_W      = TOF_TS_W
`endif
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [N_SENSORS-1:0]               dist_valid,
    input  logic [N_SENSORS-1:0][DIST_W-1:0]   dist_data,
    output logic                               m_valid,
    input  logic                               m_ready,
    output logic [$clog2(N_SENSORS)-1:0]       m_index,
    output logic [DIST_W-1:0]                  m_distance,
`ifdef TOF_TIMESTAMP_EN
    output logic [TS_W-1:0]                    m_timestamp,
`endif
    output logic [$clog2(DEPTH):0]             fifo_level,
    output logic [N_SENSORS-1:0]               overrun,
    input  logic                               overrun_clr
);

    localparam int IDX_W = $clog2(N_SENSORS);

    logic [N_SENSORS-1:0][DIST_W-1:0] slot_q, slot_d;
    logic [N_SENSORS-1:0]             pend_q, pend_d;
    logic [N_SENSORS-1:0]             overrun_q, overrun_d;
    logic [IDX_W-1:0]                 rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]                 gnt_idx;
    logic [N_SENSORS-1:0]             grant_vec;
    logic                             gnt_found;
    logic                             push;
    logic                             fifo_full;
    logic                             fifo_empty;
    tof_sample_t                      push_data;
    tof_sample_t                      head;

`ifdef TOF_TIMESTAMP_EN
    logic [TS_W-1:0]                  ts_q, ts_d;
    logic [N_SENSORS-1:0][TS_W-1:0]   slot_ts_q, slot_ts_d;
`endif

    // Search starts just after the last grant so every sensor gets a turn.
    always_comb begin
        logic [IDX_W-1:0] cand;
        cand      = '0;
        gnt_found = 1'b0;
        gnt_idx   = rr_ptr_q;
        for (int k = 1; k <= N_SENSORS; k++) begin
            cand = IDX_W'((int'(rr_ptr_q) + k) % N_SENSORS);
            if (!gnt_found && pend_q[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
        push      = gnt_found && !fifo_full;
        grant_vec = '0;
        if (push) begin
            grant_vec[gnt_idx] = 1'b1;
        end
        rr_ptr_d  = push ? gnt_idx : rr_ptr_q;

        push_data          = '0;
        push_data.index    = gnt_idx;
        push_data.distance = slot_q[gnt_idx];
`ifdef TOF_TIMESTAMP_EN
        push_data.timestamp = slot_ts_q[gnt_idx];
`endif
    end

    // A granted slot hands its old value to the FIFO, so a same-cycle
    // strobe on that sensor is a refill rather than an overrun.
    always_comb begin
        slot_d    = slot_q;
        pend_d    = pend_q & ~grant_vec;
        overrun_d = overrun_clr ? '0 : overrun_q;
`ifdef TOF_TIMESTAMP_EN
        ts_d      = ts_q + 1'b1;
        slot_ts_d = slot_ts_q;
`endif
        for (int i = 0; i < N_SENSORS; i++) begin
            if (dist_valid[i]) begin
                slot_d[i] = dist_data[i];
                pend_d[i] = 1'b1;
`ifdef TOF_TIMESTAMP_EN
                slot_ts_d[i] = ts_q;
`endif
                if (pend_q[i] && !grant_vec[i]) begin
                    overrun_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_q    <= '0;
            pend_q    <= '0;
            overrun_q <= '0;
            rr_ptr_q  <= IDX_W'(N_SENSORS - 1);
`ifdef TOF_TIMESTAMP_EN
            ts_q      <= '0;
            slot_ts_q <= '0;
`endif
        end else begin
            slot_q    <= slot_d;
            pend_q    <= pend_d;
            overrun_q <= overrun_d;
            rr_ptr_q  <= rr_ptr_d;
`ifdef TOF_TIMESTAMP_EN
            ts_q      <= ts_d;
            slot_ts_q <= slot_ts_d;
`endif
        end
    end

    tof_sample_fifo #(
        .DEPTH (DEPTH),
        .T     (tof_sample_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (m_valid && m_ready),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_comb begin
        m_valid     = !fifo_empty;
        m_index     = head.index;
        m_distance  = head.distance;
`ifdef TOF_TIMESTAMP_EN
        m_timestamp = head.timestamp;
`endif
        overrun     = overrun_q;
    end

endmodule

// File: tb/tb_tof_distance_collector.sv
// Bench for tof_distance_collector: directed vector table, a mid-stream
// reset sequence, and randomized traffic against a queue-based model.
module tb_tof_distance_collector;

    localparam int N     = 8;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic                   clk;
    logic                   reset;
    logic [N-1:0]           dist_valid;
    logic [N-1:0][DW-1:0]   dist_data;
    logic                   m_valid;
    logic                   m_ready;
    logic [2:0]             m_index;
    logic [DW-1:0]          m_distance;
`ifdef TOF_TIMESTAMP_EN
    logic [15:0]            m_timestamp;
`endif
    logic [LW-1:0]          fifo_level;
    logic [N-1:0]           overrun;
    logic                   overrun_clr;

    int checks   = 0;
    int failures = 0;

    tof_distance_collector #(
        .N_SENSORS (N),
        .DIST_W    (DW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .dist_valid  (dist_valid),
        .dist_data   (dist_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_index     (m_index),
        .m_distance  (m_distance),
`ifdef TOF_TIMESTAMP_EN
        .m_timestamp (m_timestamp),
`endif
        .fifo_level  (fifo_level),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [7:0] dv, input logic [15:0] base,
                         input logic rdy, input logic clr);
        dist_valid  = dv;
        for (int i = 0; i < N; i++) dist_data[i] = base + 16'(i);
        m_ready     = rdy;
        overrun_clr = clr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset is asserted between edges; outputs must clear before any clock.
    task automatic do_reset();
        drive(8'h00, 16'h0, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_index", 32'(m_index), 32'd0);
        chk("rst_dist", 32'(m_distance), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        chk("rst_pend", 32'(dut.pend_q), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    typedef struct {
        string        tag;
        bit           rst;
        logic [7:0]   dv;
        logic [15:0]  base;
        logic         rdy;
        logic         clr;
        logic         ev;
        logic [2:0]   ei;
        logic [15:0]  ed;
        int           el;
        logic [7:0]   eo;
        bit           cp;
        logic [7:0]   ep;
    } tv_t;

    tv_t tbl[$];

    function automatic tv_t r(string tag, bit rst, logic [7:0] dv, logic [15:0] base,
                              logic rdy, logic clr, logic ev, logic [2:0] ei,
                              logic [15:0] ed, int el, logic [7:0] eo);
        tv_t t;
        t.tag = tag; t.rst = rst; t.dv = dv; t.base = base; t.rdy = rdy;
        t.clr = clr; t.ev = ev; t.ei = ei; t.ed = ed; t.el = el; t.eo = eo;
        t.cp = 1'b0; t.ep = 8'h00;
        return t;
    endfunction

    // Behavioural reference: slots and pending flags as arrays, FIFO as a queue.
    typedef struct {
        int          idx;
        logic [15:0] d;
    } ent_t;

    bit          m_pend [N];
    logic [15:0] m_slot [N];
    int          m_rr;
    logic [7:0]  m_ovr;
    ent_t        m_q[$];

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 1'b0;
            m_slot[i] = '0;
        end
        m_rr  = N - 1;
        m_ovr = '0;
        m_q.delete();
    endtask

    task automatic model_step(input logic [7:0] dv, input logic [N-1:0][DW-1:0] dd,
                              input logic rdy, input logic clr);
        bit   do_pop;
        int   g;
        ent_t e;
        do_pop = (m_q.size() > 0) && rdy;
        g = -1;
        if (m_q.size() < DEPTH) begin
            for (int k = 1; k <= N; k++) begin
                int j;
                j = (m_rr + k) % N;
                if (g < 0 && m_pend[j]) g = j;
            end
        end
        if (g >= 0) begin
            e.idx = g;
            e.d   = m_slot[g];
            m_pend[g] = 1'b0;
            m_rr = g;
        end
        if (clr) m_ovr = '0;
        for (int i = 0; i < N; i++) begin
            if (dv[i]) begin
                if (m_pend[i]) m_ovr[i] = 1'b1;
                m_slot[i] = dd[i];
                m_pend[i] = 1'b1;
            end
        end
        if (do_pop) void'(m_q.pop_front());
        if (g >= 0) m_q.push_back(e);
    endtask

    initial begin
        tv_t t;
        reset       = 1'b0;
        dist_valid  = '0;
        dist_data   = '0;
        m_ready     = 1'b0;
        overrun_clr = 1'b0;

        // Single sample on sensor 3
        tbl.push_back(r("single_cap", 1, 8'h08, 16'h01F1, 1, 0, 0, 0, 16'h0, 0, 8'h00));
        tbl.push_back(r("single_out", 0, 8'h00, 16'h0000, 1, 0, 1, 3, 16'h01F4, 1, 8'h00));
        tbl.push_back(r("single_pop", 0, 8'h00, 16'h0000, 1, 0, 0, 0, 16'h0, 0, 8'h00));
        // All sensors at once
        tbl.push_back(r("all_cap", 1, 8'hFF, 16'd100, 1, 0, 0, 0, 16'h0, 0, 8'h00));
        for (int k = 0; k < N; k++)
            tbl.push_back(r("all_out", 0, 8'h00, 16'h0, 1, 0, 1, 3'(k), 16'(100 + k), 1, 8'h00));
        tbl.push_back(r("all_done", 0, 8'h00, 16'h0, 1, 0, 0, 0, 16'h0, 0, 8'h00));
        // Backpressure with a 4-deep FIFO
        tbl.push_back(r("bp_cap", 1, 8'hFF, 16'd100, 0, 0, 0, 0, 16'h0, 0, 8'h00));
        for (int k = 1; k <= 4; k++)
            tbl.push_back(r("bp_fill", 0, 8'h00, 16'h0, 0, 0, 1, 0, 16'd100, k, 8'h00));
        t = r("bp_full", 0, 8'h00, 16'h0, 0, 0, 1, 0, 16'd100, 4, 8'h00);
        t.cp = 1'b1; t.ep = 8'hF0;
        tbl.push_back(t);
        for (int k = 1; k <= 5; k++)
            tbl.push_back(r("bp_drain", 0, 8'h00, 16'h0, 1, 0, 1, 3'(k), 16'(100 + k), 3, 8'h00));
        tbl.push_back(r("bp_drain", 0, 8'h00, 16'h0, 1, 0, 1, 6, 16'd106, 2, 8'h00));
        tbl.push_back(r("bp_drain", 0, 8'h00, 16'h0, 1, 0, 1, 7, 16'd107, 1, 8'h00));
        tbl.push_back(r("bp_done", 0, 8'h00, 16'h0, 1, 0, 0, 0, 16'h0, 0, 8'h00));
        // Overrun of sensor 5 while the FIFO is full
        tbl.push_back(r("ov_cap", 1, 8'h0F, 16'h0, 0, 0, 0, 0, 16'h0, 0, 8'h00));
        for (int k = 1; k <= 4; k++)
            tbl.push_back(r("ov_fill", 0, 8'h00, 16'h0, 0, 0, 1, 0, 16'h0, k, 8'h00));
        tbl.push_back(r("ov_first", 0, 8'h20, 16'd5, 0, 0, 1, 0, 16'h0, 4, 8'h00));
        tbl.push_back(r("ov_second", 0, 8'h20, 16'd15, 0, 0, 1, 0, 16'h0, 4, 8'h20));
        tbl.push_back(r("ov_drain", 0, 8'h00, 16'h0, 1, 0, 1, 1, 16'd1, 3, 8'h20));
        tbl.push_back(r("ov_drain", 0, 8'h00, 16'h0, 1, 0, 1, 2, 16'd2, 3, 8'h20));
        tbl.push_back(r("ov_drain", 0, 8'h00, 16'h0, 1, 0, 1, 3, 16'd3, 2, 8'h20));
        tbl.push_back(r("ov_latest", 0, 8'h00, 16'h0, 1, 0, 1, 5, 16'd20, 1, 8'h20));
        tbl.push_back(r("ov_empty", 0, 8'h00, 16'h0, 1, 0, 0, 0, 16'h0, 0, 8'h20));
        tbl.push_back(r("ov_clr", 0, 8'h00, 16'h0, 1, 1, 0, 0, 16'h0, 0, 8'h00));
        tbl.push_back(r("ov2_cap", 0, 8'h0F, 16'h0, 0, 0, 0, 0, 16'h0, 0, 8'h00));
        for (int k = 1; k <= 4; k++)
            tbl.push_back(r("ov2_fill", 0, 8'h00, 16'h0, 0, 0, 1, 0, 16'h0, k, 8'h00));
        tbl.push_back(r("ov2_first", 0, 8'h02, 16'h0, 0, 0, 1, 0, 16'h0, 4, 8'h00));
        tbl.push_back(r("ov2_clr_hit", 0, 8'h02, 16'h0, 0, 1, 1, 0, 16'h0, 4, 8'h02));
        // Same-channel collision, then rotation past rr_ptr=2
        tbl.push_back(r("col_cap", 1, 8'h04, 16'h000F, 0, 0, 0, 0, 16'h0, 0, 8'h00));
        tbl.push_back(r("col_hit", 0, 8'h04, 16'h0031, 0, 0, 1, 2, 16'h0011, 1, 8'h00));
        tbl.push_back(r("col_again", 0, 8'h00, 16'h0, 0, 0, 1, 2, 16'h0011, 2, 8'h00));
        tbl.push_back(r("col_pop", 0, 8'h00, 16'h0, 1, 0, 1, 2, 16'h0033, 1, 8'h00));
        tbl.push_back(r("col_empty", 0, 8'h00, 16'h0, 1, 0, 0, 0, 16'h0, 0, 8'h00));
        tbl.push_back(r("rot_cap", 0, 8'h44, 16'h0050, 1, 0, 0, 0, 16'h0, 0, 8'h00));
        tbl.push_back(r("rot_six", 0, 8'h00, 16'h0, 1, 0, 1, 6, 16'h0056, 1, 8'h00));
        tbl.push_back(r("rot_two", 0, 8'h00, 16'h0, 1, 0, 1, 2, 16'h0052, 1, 8'h00));
        tbl.push_back(r("rot_empty", 0, 8'h00, 16'h0, 1, 0, 0, 0, 16'h0, 0, 8'h00));

        #2;
        foreach (tbl[n]) begin
            t = tbl[n];
            if (t.rst) do_reset();
            drive(t.dv, t.base, t.rdy, t.clr);
            step();
            chk({t.tag, "_valid"}, 32'(m_valid), 32'(t.ev));
            chk({t.tag, "_level"}, 32'(fifo_level), 32'(t.el));
            chk({t.tag, "_ovr"}, 32'(overrun), 32'(t.eo));
            if (t.ev) begin
                chk({t.tag, "_index"}, 32'(m_index), 32'(t.ei));
                chk({t.tag, "_dist"}, 32'(m_distance), 32'(t.ed));
            end
            if (t.cp) chk({t.tag, "_pend"}, 32'(dut.pend_q), 32'(t.ep));
        end

        // Mid-stream reset with three buffered samples and pending slots
        do_reset();
        drive(8'hFF, 16'd200, 1'b0, 1'b0);
        step();
        drive(8'h00, 16'h0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) step();
        chk("mid_level", 32'(fifo_level), 32'd3);
        chk("mid_pend", 32'(dut.pend_q), 32'hF8);
        do_reset();
        drive(8'h01, 16'h0ABC, 1'b1, 1'b0);
        step();
        chk("post_rst_c0", 32'(m_valid), 32'd0);
        drive(8'h00, 16'h0, 1'b1, 1'b0);
        step();
        chk("post_rst_valid", 32'(m_valid), 32'd1);
        chk("post_rst_index", 32'(m_index), 32'd0);
        chk("post_rst_dist", 32'(m_distance), 32'h0ABC);
        step();
        chk("post_rst_empty", 32'(m_valid), 32'd0);

        // Randomized traffic with varying backpressure
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [7:0]          dv;
            logic [N-1:0][DW-1:0] dd;
            logic                rdy;
            logic                clr;
            int                  rdy_pct;
            rdy_pct = ((cyc / 200) % 3 == 0) ? 20 : 75;
            for (int i = 0; i < N; i++) begin
                dv[i] = ($urandom_range(0, 5) == 0);
                dd[i] = 16'($urandom);
            end
            rdy = ($urandom_range(0, 99) < rdy_pct);
            clr = ($urandom_range(0, 31) == 0);
            dist_valid  = dv;
            dist_data   = dd;
            m_ready     = rdy;
            overrun_clr = clr;
            @(posedge clk);
            model_step(dv, dd, rdy, clr);
            #1;
            chk("rand_valid", 32'(m_valid), 32'(m_q.size() > 0));
            chk("rand_level", 32'(fifo_level), 32'(m_q.size()));
            chk("rand_ovr", 32'(overrun), 32'(m_ovr));
            if (m_q.size() > 0) begin
                chk("rand_index", 32'(m_index), 32'(m_q[0].idx));
                chk("rand_dist", 32'(m_distance), 32'(m_q[0].d));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
